// File: rtl/sort_cpu.sv
// Single-cycle MIPS-subset CPU whose ROM bubble-sorts data words 0..7, with a 4-digit hex display.
// Latency: one instruction per clk_enable tick while enabled; RAM writes reach the display one clk later.
// Backpressure: none; center_button_enable_sort gates execution, and the halt loop freezes PC and memory.
// Ports: clk, reset (async, high) | left_button_display_data (index step), center_button_enable_sort (run)
//        instruction_counter (PC), finished_sort, clk_enable | DisplaySeg/DisplayAnode (active-low, multiplexed)
module sort_cpu #(
   parameter int CLK_DIV     = 4,
   parameter int REFRESH_DIV = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       left_button_display_data,
   input  logic       center_button_enable_sort,
   output logic [7:0] instruction_counter,
   output logic       finished_sort,
   output logic       clk_enable,
   output logic [6:0] DisplaySeg,
   output logic [3:0] DisplayAnode
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                          OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2b;
   localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25,
                          FN_SLT = 6'h2a;

   function automatic logic [31:0] r_op(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [5:0] fn);
      return {OP_R, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] init_word(input logic [3:0] idx);
      case (idx)
         4'd0: return 32'd23;
         4'd1: return 32'd7;
         4'd2: return 32'd42;
         4'd3: return 32'd5;
         4'd4: return 32'd18;
         4'd5: return 32'd99;
         4'd6: return 32'd1;
         4'd7: return 32'd64;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);  // active-high, bit0 = a
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   logic [DW-1:0] div_cnt;
   logic [7:0]    pc, pc_next;
   logic [31:0]   regs [32];
   logic [31:0]   ram  [16];
   logic [31:0]   instr;
   logic          exec;

   // Program: r6 = 0x80000000 bias (0xFFFF8000 doubled 16 times), then bubble sort.
   // Adding the bias to both operands flips their MSBs so signed slt acts as an unsigned compare.
   always_comb begin
      case (pc[5:0])
         6'd0:  instr = i_op(OP_ADDI, 5'd6, 5'd0, 16'h8000);
         6'd1:  instr = i_op(OP_ADDI, 5'd7, 5'd0, 16'd16);
         6'd2:  instr = r_op(5'd6, 5'd6, 5'd6, FN_ADD);           // bias loop
         6'd3:  instr = i_op(OP_ADDI, 5'd7, 5'd7, 16'hFFFF);
         6'd4:  instr = i_op(OP_BNE, 5'd0, 5'd7, 16'hFFFD);       // -> 2
         6'd5:  instr = i_op(OP_ADDI, 5'd1, 5'd0, 16'd7);         // r1 = compares this pass
         6'd6:  instr = i_op(OP_ADDI, 5'd2, 5'd0, 16'd0);         // outer: r2 = byte pointer
         6'd7:  instr = i_op(OP_ADDI, 5'd3, 5'd1, 16'd0);         // r3 = inner count
         6'd8:  instr = i_op(OP_LW, 5'd4, 5'd2, 16'd0);           // inner
         6'd9:  instr = i_op(OP_LW, 5'd5, 5'd2, 16'd4);
         6'd10: instr = r_op(5'd8, 5'd4, 5'd6, FN_ADD);
         6'd11: instr = r_op(5'd9, 5'd5, 5'd6, FN_ADD);
         6'd12: instr = r_op(5'd10, 5'd9, 5'd8, FN_SLT);          // next < current ?
         6'd13: instr = i_op(OP_BEQ, 5'd0, 5'd10, 16'd2);         // -> 16
         6'd14: instr = i_op(OP_SW, 5'd5, 5'd2, 16'd0);
         6'd15: instr = i_op(OP_SW, 5'd4, 5'd2, 16'd4);
         6'd16: instr = i_op(OP_ADDI, 5'd2, 5'd2, 16'd4);
         6'd17: instr = i_op(OP_ADDI, 5'd3, 5'd3, 16'hFFFF);
         6'd18: instr = i_op(OP_BNE, 5'd0, 5'd3, 16'hFFF5);       // -> 8
         6'd19: instr = i_op(OP_ADDI, 5'd1, 5'd1, 16'hFFFF);
         6'd20: instr = i_op(OP_BNE, 5'd0, 5'd1, 16'hFFF1);       // -> 6
         6'd21: instr = {OP_J, 26'd21};                           // halt
         default: instr = 32'd0;                                  // unimplemented: no-op
      endcase
   end

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] rs_val, rt_val, simm, addr_sum, wr_dat;
   logic [4:0]  wr_addr;
   logic        reg_we, mem_we;
   logic        unused_bits;

   assign op          = instr[31:26];
   assign rs          = instr[25:21];
   assign rt          = instr[20:16];
   assign rd          = instr[15:11];
   assign funct       = instr[5:0];
   assign simm        = {{16{instr[15]}}, instr[15:0]};
   assign rs_val      = (rs == 5'd0) ? 32'd0 : regs[rs];
   assign rt_val      = (rt == 5'd0) ? 32'd0 : regs[rt];
   assign addr_sum    = rs_val + simm;
   assign unused_bits = &{1'b0, instr[10:6]};

   always_comb begin
      pc_next = pc + 8'd1;
      reg_we  = 1'b0;
      mem_we  = 1'b0;
      wr_addr = rt;
      wr_dat  = addr_sum;
      case (op)
         OP_R: begin
            wr_addr = rd;
            reg_we  = 1'b1;
            case (funct)
               FN_ADD:  wr_dat = rs_val + rt_val;
               FN_SUB:  wr_dat = rs_val - rt_val;
               FN_AND:  wr_dat = rs_val & rt_val;
               FN_OR:   wr_dat = rs_val | rt_val;
               FN_SLT:  wr_dat = {31'd0, $signed(rs_val) < $signed(rt_val)};
               default: reg_we = 1'b0;
            endcase
         end
         OP_ADDI: reg_we = 1'b1;
         OP_LW: begin
            reg_we = 1'b1;
            wr_dat = ram[addr_sum[5:2]];
         end
         OP_SW:   mem_we = 1'b1;
         OP_BEQ:  if (rs_val == rt_val) pc_next = pc + 8'd1 + simm[7:0];
         OP_BNE:  if (rs_val != rt_val) pc_next = pc + 8'd1 + simm[7:0];
         OP_J:    pc_next = {2'b00, instr[5:0]};
         default: ;
      endcase
   end

   assign clk_enable          = (div_cnt == DW'(CLK_DIV - 1));
   assign exec                = clk_enable & center_button_enable_sort;
   assign finished_sort       = (op == OP_J) && ({2'b00, instr[5:0]} == pc);
   assign instruction_counter = pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) div_cnt <= '0;
      else       div_cnt <= clk_enable ? '0 : div_cnt + DW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= 8'd0;
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
         for (int i = 0; i < 16; i++) ram[i] <= init_word(i[3:0]);
      end else if (exec) begin
         pc <= pc_next;
         if (reg_we && (wr_addr != 5'd0)) regs[wr_addr] <= wr_dat;
         if (mem_we) ram[addr_sum[5:2]] <= rt_val;
      end
   end

   // Display: two-flop synchroniser plus one delay flop for rising-edge detection.
   logic [2:0]    btn_sync;
   logic [2:0]    disp_idx;
   logic [RW-1:0] refresh_cnt;
   logic [1:0]    digit_sel;
   logic [7:0]    disp_byte;
   logic [3:0]    nib;
   logic          blank;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_sync    <= 3'd0;
         disp_idx    <= 3'd0;
         refresh_cnt <= '0;
         digit_sel   <= 2'd0;
      end else begin
         btn_sync <= {btn_sync[1:0], left_button_display_data};
         if (btn_sync[1] && !btn_sync[2]) disp_idx <= disp_idx + 3'd1;
         if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_sel   <= digit_sel + 2'd1;
         end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
         end
      end
   end

   assign disp_byte = ram[{1'b0, disp_idx}][7:0];

   always_comb begin
      nib   = 4'h0;
      blank = 1'b0;
      case (digit_sel)
         2'd0:    nib   = disp_byte[3:0];
         2'd1:    nib   = disp_byte[7:4];
         2'd2:    blank = 1'b1;
         default: nib   = {1'b0, disp_idx};
      endcase
   end

   assign DisplaySeg   = blank ? 7'h7F : ~hex_glyph(nib);
   assign DisplayAnode = ~(4'b0001 << digit_sel);

endmodule

// File: tb/tb_sort_cpu.sv
// Bench for sort_cpu: drives reset/run/button stimulus and reads RAM back through the display.
// Expected display readings are queued as each read is requested and popped when the digits are decoded.
module tb_sort_cpu;
   localparam int CLK_DIV     = 4;
   localparam int REFRESH_DIV = 16;

   logic       clk = 1'b0;
   logic       reset, btn, en;
   logic [7:0] instruction_counter;
   logic       finished_sort, clk_enable;
   logic [6:0] DisplaySeg;
   logic [3:0] DisplayAnode;

   sort_cpu #(.CLK_DIV(CLK_DIV), .REFRESH_DIV(REFRESH_DIV)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .left_button_display_data  (btn),
      .center_button_enable_sort (en),
      .instruction_counter       (instruction_counter),
      .finished_sort             (finished_sort),
      .clk_enable                (clk_enable),
      .DisplaySeg                (DisplaySeg),
      .DisplayAnode              (DisplayAnode)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cur_idx  = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];
   int          init_vals[8] = '{23, 7, 42, 5, 18, 99, 1, 64};
   int          sorted_vals[8];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic sb_pop_check(input logic [31:0] got);
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else check(tag_q.pop_front(), got, exp_q.pop_front());
   endtask

   function automatic int seg_to_hex(input logic [6:0] seg);
      case (~seg)
         7'h3F: return 0;   7'h06: return 1;   7'h5B: return 2;   7'h4F: return 3;
         7'h66: return 4;   7'h6D: return 5;   7'h7D: return 6;   7'h07: return 7;
         7'h7F: return 8;   7'h6F: return 9;   7'h77: return 10;  7'h7C: return 11;
         7'h39: return 12;  7'h5E: return 13;  7'h79: return 14;  7'h71: return 15;
         7'h00: return 16;  // blank
         default: return -1;
      endcase
   endfunction

   task automatic wait_digit(input logic [3:0] an, output int v);
      int n = 0;
      v = -1;
      while (DisplayAnode !== an && n < 4 * REFRESH_DIV + 8) begin
         @(negedge clk);
         n++;
      end
      if (DisplayAnode === an) v = seg_to_hex(DisplaySeg);
      else check("anode_wait", {28'd0, DisplayAnode}, {28'd0, an});
   endtask

   task automatic read_display(output int idx, output int val);
      int d3, d2, d1, d0;
      wait_digit(4'b0111, d3);
      wait_digit(4'b1011, d2);
      wait_digit(4'b1101, d1);
      wait_digit(4'b1110, d0);
      check("digit2_blank", 32'(d2), 32'd16);
      idx = d3;
      val = (d1 < 0 || d1 > 15 || d0 < 0 || d0 > 15) ? -1 : d1 * 16 + d0;
   endtask

   task automatic press();
      @(negedge clk); btn = 1'b1;
      repeat (4) @(negedge clk);
      btn = 1'b0;
      repeat (4) @(negedge clk);
      cur_idx = (cur_idx + 1) % 8;
   endtask

   task automatic read_one(input string pfx, input int exp_idx, input int exp_val);
      int idx, val;
      sb_push({pfx, "_idx"}, 32'(exp_idx));
      sb_push($sformatf("%s_word%0d", pfx, exp_idx), 32'(exp_val));
      read_display(idx, val);
      sb_pop_check(32'(idx));
      sb_pop_check(32'(val));
   endtask

   task automatic read_words(input bit sorted, input string pfx);
      for (int k = 0; k < 8; k++) begin
         while (cur_idx != k) press();
         read_one(pfx, k, sorted ? sorted_vals[k] : init_vals[k]);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cur_idx = 0;
   endtask

   task automatic run_to_finish(input string pfx);
      int n = 0, ticks = 0, moves = 0, drops = 0;
      logic [7:0] halt_pc;
      en = 1'b1;
      while (!finished_sort && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check({pfx, "_finished"}, {31'd0, finished_sort}, 32'd1);
      halt_pc = instruction_counter;
      n = 0;
      while (ticks < 50 && n < 50 * CLK_DIV * 2) begin
         @(negedge clk);
         n++;
         if (clk_enable) ticks++;
         if (instruction_counter !== halt_pc) moves++;
         if (finished_sort !== 1'b1) drops++;
      end
      check({pfx, "_halt_ticks"}, 32'(ticks), 32'd50);
      check({pfx, "_halt_pc_moves"}, 32'(moves), 32'd0);
      check({pfx, "_halt_finish_drops"}, 32'(drops), 32'd0);
      en = 1'b0;
   endtask

   initial begin
      int pulses = 0, moves = 0;
      int pulse_at[3];
      int tmp;

      // Reference result: simple insertion sort of the initial data.
      sorted_vals = init_vals;
      for (int i = 1; i < 8; i++)
         for (int j = i; j > 0 && sorted_vals[j-1] > sorted_vals[j]; j--) begin
            tmp = sorted_vals[j]; sorted_vals[j] = sorted_vals[j-1]; sorted_vals[j-1] = tmp;
         end

      reset = 1'b1; btn = 1'b0; en = 1'b0;
      #12;
      check("rst_pc", {24'd0, instruction_counter}, 32'd0);
      check("rst_clk_enable", {31'd0, clk_enable}, 32'd0);
      check("rst_finished", {31'd0, finished_sort}, 32'd0);
      check("rst_anode", {28'd0, DisplayAnode}, 32'b1110);
      check("rst_seg", 32'(seg_to_hex(DisplaySeg)), 32'(init_vals[0] % 16));
      @(negedge clk); reset = 1'b0;

      // Disabled CPU: PC and RAM must hold.
      repeat (100) begin
         @(negedge clk);
         if (instruction_counter !== 8'd0) moves++;
      end
      check("idle_pc_moves", 32'(moves), 32'd0);
      read_words(1'b0, "idle");
      press();
      read_one("wrap_from7", 0, init_vals[0]);

      // Tick spacing and straight-line execution.
      do_reset();
      en = 1'b1;
      for (int c = 1; c <= 3 * CLK_DIV; c++) begin
         @(negedge clk);
         if (clk_enable) begin
            if (pulses < 3) pulse_at[pulses] = c;
            pulses++;
         end
      end
      en = 1'b0;
      check("tick_count", 32'(pulses), 32'd3);
      if (pulses >= 3) begin
         check("tick_gap1", 32'(pulse_at[1] - pulse_at[0]), 32'(CLK_DIV));
         check("tick_gap2", 32'(pulse_at[2] - pulse_at[1]), 32'(CLK_DIV));
      end
      check("pc_after_3", {24'd0, instruction_counter}, 32'd3);

      run_to_finish("sort1");
      read_words(1'b1, "sort1");

      // Index stepping after the sort: 7 -> 0, then 5 edges, then 3 more wrap to 0.
      press();
      read_one("step_wrap", 0, sorted_vals[0]);
      repeat (5) press();
      read_one("step5", 5, 8'h2A);
      repeat (3) press();
      read_one("step8_wrap", 0, sorted_vals[0]);

      // Mid-run reset aborts the sort and restores the data.
      do_reset();
      en = 1'b1;
      repeat (300) @(negedge clk);
      check("mid_not_finished", {31'd0, finished_sort}, 32'd0);
      check("mid_running", {31'd0, instruction_counter != 8'd0}, 32'd1);
      @(posedge clk); #2 reset = 1'b1;
      #1;
      check("mid_rst_pc", {24'd0, instruction_counter}, 32'd0);
      check("mid_rst_finished", {31'd0, finished_sort}, 32'd0);
      check("mid_rst_seg", 32'(seg_to_hex(DisplaySeg)), 32'(init_vals[0] % 16));
      en = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cur_idx = 0;
      read_one("mid_rst", 0, init_vals[0]);
      run_to_finish("sort2");
      read_words(1'b1, "sort2");

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
